// File: rtl/dac_spi_pkg.sv
// Shared types and command-word layout for the dual 12-bit SPI DAC writer.
// Frame bit positions follow the MCP4822 command format.
package dac_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP,
    LDAC
  } state_t;

  localparam int CMD_CH_BIT   = 15;
  localparam int CMD_GA_BIT   = 13;
  localparam int CMD_SHDN_BIT = 12;
  localparam int DAC_W        = 12;
  localparam int FRAME_W      = 16;

  function automatic logic [FRAME_W-1:0] make_cmd(
    input logic             ch,
    input logic             ga,
    input logic             shdn,
    input logic [DAC_W-1:0] data
  );
    logic [FRAME_W-1:0] w;
    w               = '0;
    w[CMD_CH_BIT]   = ch;
    w[CMD_GA_BIT]   = ga;
    w[CMD_SHDN_BIT] = shdn;
    w[DAC_W-1:0]    = data;
    return w;
  endfunction

endpackage

// File: rtl/dac_spi_writer_shifter.sv
// Serialises one SPI mode-0 frame, MSB first.
// load presets mosi to bit 15; start runs 16 bits of 2*CLK_DIV cycles.
module spi_word_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  input  logic               start,
  output logic               sclk,
  output logic               mosi,
  output logic               busy,
  output logic               last
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_W);
  localparam logic [HW-1:0] HALF_END = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(FRAME_W - 1);

  logic [HW-1:0]      half;
  logic [BW-1:0]      bitc;
  logic [FRAME_W-1:0] shreg;

  assign last = busy && sclk && (half == HALF_END) && (bitc == BIT_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      sclk  <= 1'b0;
      mosi  <= 1'b0;
      half  <= '0;
      bitc  <= '0;
      shreg <= '0;
    end else if (load) begin
      shreg <= word;
      mosi  <= word[FRAME_W-1];
    end else if (start) begin
      busy <= 1'b1;
      sclk <= 1'b0;
      half <= '0;
      bitc <= '0;
    end else if (busy) begin
      if (half != HALF_END) begin
        half <= half + 1'b1;
      end else begin
        half <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
        end else if (last) begin
          busy <= 1'b0;
          sclk <= 1'b0;
          mosi <= 1'b0;
        end else begin
          // data only moves on the falling edge
          sclk  <= 1'b0;
          bitc  <= bitc + 1'b1;
          shreg <= {shreg[FRAME_W-2:0], 1'b0};
          mosi  <= shreg[FRAME_W-2];
        end
      end
    end
  end

endmodule

// File: rtl/dac_spi_writer.sv
// Writes channel A then B to a dual SPI DAC, then pulses LDAC.
// Strobes arriving outside IDLE are dropped and flagged as overrun.
module dac_spi_writer
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int LDAC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_strobe,
  input  logic [DAC_W-1:0] dacA_word,
  input  logic [DAC_W-1:0] dacB_word,
  input  logic [1:0]       dac_gain_1x,
  input  logic [1:0]       dac_active,
  input  logic             ovr_clr,
  output logic             spi_sclk,
  output logic             spi_mosi,
  output logic             spi_cs_n,
  output logic             dac_ldac_n,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LDAC_END  = CW'(LDAC_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               word_b;
  logic [FRAME_W-1:0] frame_b;
  logic               sh_load;
  logic               sh_start;
  logic [FRAME_W-1:0] sh_word;
  logic               sh_busy;
  logic               sh_last;
  logic               accept;

  assign accept = (state == IDLE) && sample_strobe;

  always_comb begin
    state_nxt = state;
    sh_load   = 1'b0;
    sh_start  = 1'b0;
    sh_word   = make_cmd(1'b0, dac_gain_1x[0], dac_active[0], dacA_word);
    unique case (state)
      IDLE: begin
        if (sample_strobe) begin
          state_nxt = CS_SETUP;
          sh_load   = 1'b1;
        end
      end
      CS_SETUP: begin
        if (cnt == SETUP_END && !sh_busy) begin
          state_nxt = SHIFT;
          sh_start  = 1'b1;
        end
      end
      SHIFT: begin
        if (sh_last) state_nxt = CS_HOLD;
      end
      CS_HOLD: begin
        if (cnt == SETUP_END) state_nxt = GAP;
      end
      GAP: begin
        if (cnt == GAP_END) begin
          if (word_b) begin
            state_nxt = LDAC;
          end else begin
            state_nxt = CS_SETUP;
            sh_load   = 1'b1;
            sh_word   = frame_b;
          end
        end
      end
      LDAC: begin
        if (cnt == LDAC_END) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      word_b     <= 1'b0;
      frame_b    <= '0;
      spi_cs_n   <= 1'b1;
      dac_ldac_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      if (accept) begin
        word_b  <= 1'b0;
        frame_b <= make_cmd(1'b1, dac_gain_1x[1], dac_active[1], dacB_word);
      end else if (state == GAP && state_nxt == CS_SETUP) begin
        word_b <= 1'b1;
      end
      // outputs are registered from the next state
      spi_cs_n   <= !(state_nxt inside {CS_SETUP, SHIFT, CS_HOLD});
      dac_ldac_n <= (state_nxt != LDAC);
      busy       <= (state_nxt != IDLE);
      done       <= (state == LDAC) && (state_nxt == IDLE);
      if (sample_strobe && state != IDLE) overrun <= 1'b1;
      else if (ovr_clr)                   overrun <= 1'b0;
    end
  end

  spi_word_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .load (sh_load),
    .word (sh_word),
    .start(sh_start),
    .sclk (spi_sclk),
    .mosi (spi_mosi),
    .busy (sh_busy),
    .last (sh_last)
  );

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: default and fast-parameter instances share stimulus.
// Frames are rebuilt from sampled SPI pins and compared with a command-word model.
module tb_dac_spi_writer;

  localparam int N  = 400;
  localparam int SC = 6;
  localparam int MO = 5;
  localparam int CS = 4;
  localparam int LD = 3;
  localparam int BU = 2;
  localparam int DN = 1;
  localparam int OV = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_strobe = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [11:0] dacA_word = '0;
  logic [11:0] dacB_word = '0;
  logic [1:0]  gain = 2'b11;
  logic [1:0]  active = 2'b11;

  logic s0_sclk, s0_mosi, s0_cs_n, s0_ldac_n, s0_busy, s0_done, s0_ovr;
  logic s1_sclk, s1_mosi, s1_cs_n, s1_ldac_n, s1_busy, s1_done, s1_ovr;

  int checks = 0;
  int errors = 0;

  logic        stb_at[N];
  logic        clr_at[N];
  logic        rst_at[N];
  logic [11:0] wa[N];
  logic [11:0] wb[N];
  logic [6:0]  o0[N];
  logic [6:0]  o1[N];

  logic [15:0] wq[$];
  int          rq[$];

  always #5 clk = ~clk;

  dac_spi_writer dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .dacA_word(dacA_word), .dacB_word(dacB_word),
    .dac_gain_1x(gain), .dac_active(active), .ovr_clr(ovr_clr),
    .spi_sclk(s0_sclk), .spi_mosi(s0_mosi), .spi_cs_n(s0_cs_n),
    .dac_ldac_n(s0_ldac_n), .busy(s0_busy), .done(s0_done),
    .overrun(s0_ovr)
  );

  dac_spi_writer #(
    .CLK_DIV(1), .GAP_CYCLES(1), .LDAC_CYCLES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .dacA_word(dacA_word), .dacB_word(dacB_word),
    .dac_gain_1x(gain), .dac_active(active), .ovr_clr(ovr_clr),
    .spi_sclk(s1_sclk), .spi_mosi(s1_mosi), .spi_cs_n(s1_cs_n),
    .dac_ldac_n(s1_ldac_n), .busy(s1_busy), .done(s1_done),
    .overrun(s1_ovr)
  );

  function automatic logic [15:0] model(input bit ch, input bit g,
                                        input bit a, input logic [11:0] d);
    int r;
    r = (ch ? 32768 : 0) + (g ? 8192 : 0) + (a ? 4096 : 0) + int'(d);
    return r[15:0];
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      stb_at[i] = 1'b0;
      clr_at[i] = 1'b0;
      rst_at[i] = 1'b0;
      wa[i] = '0;
      wb[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_strobe = 1'b0;
    ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // iteration c samples cycle c outputs and drives cycle c inputs
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      o0[c] = {s0_sclk, s0_mosi, s0_cs_n, s0_ldac_n, s0_busy, s0_done, s0_ovr};
      o1[c] = {s1_sclk, s1_mosi, s1_cs_n, s1_ldac_n, s1_busy, s1_done, s1_ovr};
      rst = rst_at[c];
      sample_strobe = stb_at[c];
      ovr_clr = clr_at[c];
      dacA_word = wa[c];
      dacB_word = wb[c];
    end
    @(negedge clk);
    rst = 1'b0;
    sample_strobe = 1'b0;
    ovr_clr = 1'b0;
  endtask

  task automatic decode(input bit fast, input int n);
    logic [6:0]  v;
    logic        pcs;
    logic        psc;
    logic [15:0] w;
    int          rc;
    wq.delete();
    rq.delete();
    pcs = 1'b1;
    psc = 1'b0;
    w = '0;
    rc = 0;
    for (int c = 0; c < n; c++) begin
      v = fast ? o1[c] : o0[c];
      if (!v[CS] && v[SC] && !psc) begin
        w = {w[14:0], v[MO]};
        rc++;
      end
      if (!pcs && v[CS]) begin
        wq.push_back(w);
        rq.push_back(rc);
        w = '0;
        rc = 0;
      end
      pcs = v[CS];
      psc = v[SC];
    end
  endtask

  task automatic test_reset();
    logic [6:0] v;
    @(negedge clk);
    rst = 1'b1;
    sample_strobe = 1'b1;
    repeat (3) @(negedge clk);
    v = {s0_sclk, s0_mosi, s0_cs_n, s0_ldac_n, s0_busy, s0_done, s0_ovr};
    checks++;
    if (v !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_dut0 got %b want 0011000", v);
    end
    v = {s1_sclk, s1_mosi, s1_cs_n, s1_ldac_n, s1_busy, s1_done, s1_ovr};
    checks++;
    if (v !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_dut1 got %b want 0011000", v);
    end
    sample_strobe = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (s0_busy !== 1'b0 || s0_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle busy=%b cs_n=%b want 0 1", s0_busy, s0_cs_n);
    end
  endtask

  task automatic test_frame(input logic [11:0] a, input logic [11:0] b,
                            input logic [1:0] g, input logic [1:0] act);
    logic [15:0] ea;
    logic [15:0] eb;
    gain = g;
    active = act;
    do_reset();
    clear_stim();
    for (int c = 0; c < N; c++) begin
      wa[c] = (c == 0) ? a : 12'($urandom);
      wb[c] = (c == 0) ? b : 12'($urandom);
    end
    stb_at[0] = 1'b1;
    run(160);
    decode(1'b0, 160);
    ea = model(1'b0, g[0], act[0], a);
    eb = model(1'b1, g[1], act[1], b);
    checks++;
    if (wq.size() != 2) begin
      errors++;
      $display("FAIL frame_count got %0d want 2", wq.size());
    end else begin
      checks += 4;
      if (wq[0] !== ea) begin
        errors++;
        $display("FAIL frame_a got %h want %h", wq[0], ea);
      end
      if (wq[1] !== eb) begin
        errors++;
        $display("FAIL frame_b got %h want %h", wq[1], eb);
      end
      if (rq[0] != 16) begin
        errors++;
        $display("FAIL rises_a got %0d want 16", rq[0]);
      end
      if (rq[1] != 16) begin
        errors++;
        $display("FAIL rises_b got %0d want 16", rq[1]);
      end
    end
  endtask

  task automatic test_timing();
    int nb, fb, lb, nl, fl, nd, fd, ov;
    gain = 2'b11;
    active = 2'b11;
    do_reset();
    clear_stim();
    wa[0] = 12'h800;
    wb[0] = 12'hABC;
    stb_at[0] = 1'b1;
    run(170);
    nb = 0; fb = -1; lb = -1; nl = 0; fl = -1; nd = 0; fd = -1; ov = 0;
    for (int c = 0; c < 170; c++) begin
      if (o0[c][BU]) begin
        nb++;
        if (fb < 0) fb = c;
        lb = c;
      end
      if (!o0[c][LD]) begin
        nl++;
        if (fl < 0) fl = c;
      end
      if (o0[c][DN]) begin
        nd++;
        if (fd < 0) fd = c;
      end
      if (!o0[c][LD] && !o0[c][CS]) ov++;
    end
    checks++;
    if (o0[0][CS] !== 1'b1 || o0[1][CS] !== 1'b0) begin
      errors++;
      $display("FAIL cs_start got %b%b want 10", o0[0][CS], o0[1][CS]);
    end
    checks++;
    if (nb != 146 || fb != 1 || lb != 146) begin
      errors++;
      $display("FAIL busy_span got n=%0d %0d..%0d want 146 1..146", nb, fb, lb);
    end
    checks++;
    if (nl != 2 || fl != 145) begin
      errors++;
      $display("FAIL ldac_span got n=%0d first=%0d want 2 145", nl, fl);
    end
    checks++;
    if (nd != 1 || fd != 147) begin
      errors++;
      $display("FAIL done_pulse got n=%0d at %0d want 1 at 147", nd, fd);
    end
    checks++;
    if (ov != 0) begin
      errors++;
      $display("FAIL ldac_cs_overlap got %0d want 0", ov);
    end
  endtask

  task automatic test_overrun();
    logic [11:0] a1, b1, a2, b2;
    logic [15:0] e[4];
    a1 = 12'($urandom); b1 = 12'($urandom);
    a2 = 12'($urandom); b2 = 12'($urandom);
    gain = 2'b10;
    active = 2'b01;
    do_reset();
    clear_stim();
    for (int c = 0; c < N; c++) begin
      wa[c] = (c < 50) ? a1 : a2;
      wb[c] = (c < 50) ? b1 : b2;
    end
    stb_at[0] = 1'b1;
    stb_at[50] = 1'b1;
    stb_at[147] = 1'b1;
    stb_at[200] = 1'b1;
    clr_at[200] = 1'b1;
    clr_at[210] = 1'b1;
    run(300);
    checks += 7;
    if (o0[50][OV] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_before got %b want 0", o0[50][OV]);
    end
    if (o0[51][OV] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got %b want 1", o0[51][OV]);
    end
    if (o0[147][DN] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_done got %b want 1", o0[147][DN]);
    end
    if (o0[148][CS] !== 1'b0) begin
      errors++;
      $display("FAIL done_accept cs_n got %b want 0", o0[148][CS]);
    end
    if (o0[148][OV] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_keep got %b want 1", o0[148][OV]);
    end
    if (o0[201][OV] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins got %b want 1", o0[201][OV]);
    end
    if (o0[211][OV] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clr got %b want 0", o0[211][OV]);
    end
    decode(1'b0, 300);
    e[0] = model(1'b0, 1'b0, 1'b1, a1);
    e[1] = model(1'b1, 1'b1, 1'b0, b1);
    e[2] = model(1'b0, 1'b0, 1'b1, a2);
    e[3] = model(1'b1, 1'b1, 1'b0, b2);
    checks++;
    if (wq.size() != 4) begin
      errors++;
      $display("FAIL ovr_frames got %0d want 4", wq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wq[i] !== e[i] || rq[i] != 16) begin
          errors++;
          $display("FAIL ovr_word%0d got %h/%0d want %h/16", i, wq[i], rq[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] a1, b1, a2, b2;
    logic [3:0]  v;
    int          nl;
    a1 = 12'($urandom); b1 = 12'($urandom);
    a2 = 12'($urandom); b2 = 12'($urandom);
    gain = 2'b01;
    active = 2'b11;
    do_reset();
    clear_stim();
    for (int c = 0; c < N; c++) begin
      wa[c] = (c < 110) ? a1 : a2;
      wb[c] = (c < 110) ? b1 : b2;
    end
    stb_at[0] = 1'b1;
    rst_at[100] = 1'b1;
    stb_at[110] = 1'b1;
    run(270);
    v = {o0[101][SC], o0[101][CS], o0[101][LD], o0[101][BU]};
    checks += 3;
    if (o0[100][CS] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre cs_n got %b want 0", o0[100][CS]);
    end
    if (v !== 4'b0110) begin
      errors++;
      $display("FAIL mid_abort sclk,cs,ldac,busy got %b want 0110", v);
    end
    if (o0[257][DN] !== 1'b1) begin
      errors++;
      $display("FAIL mid_done got %b want 1", o0[257][DN]);
    end
    nl = 0;
    for (int c = 0; c < 110; c++) if (!o0[c][LD]) nl++;
    checks++;
    if (nl != 0) begin
      errors++;
      $display("FAIL mid_ldac got %0d low cycles want 0", nl);
    end
    decode(1'b0, 270);
    checks++;
    if (wq.size() != 4) begin
      errors++;
      $display("FAIL mid_frames got %0d want 4", wq.size());
    end else begin
      checks += 4;
      if (wq[0] !== model(1'b0, 1'b1, 1'b1, a1)) begin
        errors++;
        $display("FAIL mid_a1 got %h want %h", wq[0], model(1'b0, 1'b1, 1'b1, a1));
      end
      if (rq[1] >= 16) begin
        errors++;
        $display("FAIL mid_partial got %0d rises want <16", rq[1]);
      end
      if (wq[2] !== model(1'b0, 1'b1, 1'b1, a2) || rq[2] != 16) begin
        errors++;
        $display("FAIL mid_a2 got %h/%0d want %h/16", wq[2], rq[2], model(1'b0, 1'b1, 1'b1, a2));
      end
      if (wq[3] !== model(1'b1, 1'b0, 1'b1, b2) || rq[3] != 16) begin
        errors++;
        $display("FAIL mid_b2 got %h/%0d want %h/16", wq[3], rq[3], model(1'b1, 1'b0, 1'b1, b2));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] fa[4];
    logic [11:0] fbw[4];
    int          nb, nd, n1;
    gain = 2'($urandom);
    active = 2'($urandom);
    do_reset();
    clear_stim();
    for (int k = 0; k < 4; k++) begin
      fa[k] = 12'($urandom);
      fbw[k] = 12'($urandom);
      stb_at[72 * k] = 1'b1;
    end
    for (int c = 0; c < N; c++) begin
      wa[c] = fa[(c / 72) % 4];
      wb[c] = fbw[(c / 72) % 4];
    end
    run(300);
    nb = 0; nd = 0; n1 = 0;
    for (int c = 0; c < 300; c++) begin
      if (o1[c][BU]) nb++;
      if (o1[c][DN]) nd++;
      if (c >= 1 && c <= 71 && o1[c][BU]) n1++;
    end
    checks += 4;
    if (n1 != 71 || o1[72][BU] !== 1'b0 || o1[72][DN] !== 1'b1) begin
      errors++;
      $display("FAIL fast_busy got %0d busy,done=%b want 71 1", n1, o1[72][DN]);
    end
    if (nb != 284) begin
      errors++;
      $display("FAIL fast_busy_total got %0d want 284", nb);
    end
    if (nd != 4) begin
      errors++;
      $display("FAIL fast_done got %0d want 4", nd);
    end
    if (o1[299][OV] !== 1'b0) begin
      errors++;
      $display("FAIL fast_overrun got %b want 0", o1[299][OV]);
    end
    decode(1'b1, 300);
    checks++;
    if (wq.size() != 8) begin
      errors++;
      $display("FAIL fast_frames got %0d want 8", wq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wq[2*k] !== model(1'b0, gain[0], active[0], fa[k]) ||
            wq[2*k+1] !== model(1'b1, gain[1], active[1], fbw[k]) ||
            rq[2*k] != 16 || rq[2*k+1] != 16) begin
          errors++;
          $display("FAIL fast_set%0d got %h %h want %h %h", k, wq[2*k], wq[2*k+1],
                   model(1'b0, gain[0], active[0], fa[k]),
                   model(1'b1, gain[1], active[1], fbw[k]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(12'h800, 12'hABC, 2'b11, 2'b11);
    test_timing();
    test_frame(12'hFFF, 12'h000, 2'b00, 2'b01);
    for (int i = 0; i < 4; i++)
      test_frame(12'($urandom), 12'($urandom), 2'($urandom), 2'($urandom));
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
